// File: rtl/wb_mem_ctrl.sv
// Write-back memory controller: queues dirty evictions in a small FIFO,
// serves cache misses either by forwarding from the FIFO or by a memory
// read, and drains queued writes to memory whenever no miss is pending.
module wb_mem_ctrl #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_evict,
  input  logic [AW-1:0] i_evict_addr,
  input  logic [DW-1:0] i_evict_data,
  input  logic          i_miss,
  input  logic [AW-1:0] i_miss_addr,
  output logic [DW-1:0] o_memory_line,
  output logic          o_memory_response,
  output logic          o_wb_full,
  output logic          o_overflow,
  output logic          o_mem_req,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic          i_mem_ack,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {IDLE, FWD, FILL, DRAIN, RESP} state_t;

  state_t        state;
  state_t        state_next;

  logic [AW-1:0] fifo_addr [DEPTH];
  logic [DW-1:0] fifo_data [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic [AW-1:0] miss_addr;
  logic [DW-1:0] fwd_data;
  logic          push;
  logic          pop;
  logic          hit;
  logic [DW-1:0] hit_data;
  logic [PW-1:0] idx;

  // A full FIFO refuses evictions; a pop only happens when a drain write completes.
  assign o_wb_full = (count == CW'(DEPTH));
  assign push      = i_evict && !o_wb_full;
  assign pop       = (state == DRAIN) && i_mem_ack;

  // Search valid entries oldest to youngest so the youngest match wins; a
  // same-cycle accepted eviction is younger than anything stored.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (k < int'(count) && fifo_addr[idx][AW-1:2] == i_miss_addr[AW-1:2]) begin
        hit      = 1'b1;
        hit_data = fifo_data[idx];
      end
    end
    if (push && i_evict_addr[AW-1:2] == i_miss_addr[AW-1:2]) begin
      hit      = 1'b1;
      hit_data = i_evict_data;
    end
  end

  // FIFO storage needs no reset: reset empties the queue through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= i_evict_addr;
      fifo_data[wr_ptr] <= i_evict_data;
    end
  end

  // Pointer/occupancy bookkeeping and the sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_evict && o_wb_full) o_overflow <= 1'b1;
    end
  end

  // State register plus the miss capture and fill-line registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      miss_addr     <= '0;
      fwd_data      <= '0;
      o_memory_line <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && i_miss) begin
        miss_addr <= i_miss_addr;
        fwd_data  <= hit_data;
      end
      if (state == FWD)
        o_memory_line <= fwd_data;
      else if (state == FILL && i_mem_ack)
        o_memory_line <= i_mem_rdata;
    end
  end

  // Next-state and memory request outputs; requests hold steady until acked.
  always_comb begin
    state_next        = state;
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_mem_addr        = '0;
    o_mem_wdata       = '0;
    o_memory_response = 1'b0;
    case (state)
      IDLE: begin
        if (i_miss)
          state_next = hit ? FWD : FILL;
        else if (count != '0)
          state_next = DRAIN;
      end
      FWD: state_next = RESP;
      FILL: begin
        o_mem_req  = 1'b1;
        o_mem_addr = miss_addr;
        if (i_mem_ack) state_next = RESP;
      end
      DRAIN: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = fifo_addr[rd_ptr];
        o_mem_wdata = fifo_data[rd_ptr];
        if (i_mem_ack) state_next = IDLE;
      end
      RESP: begin
        o_memory_response = 1'b1;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/wb_mem_ctrl.md
WB_MEM_CTRL -- requirements
Module: wb_mem_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, write-back FIFO entries (power of 2, >=2).
REQ-002 Parameter AW, default 32, address width; DW, default 32, data/line width.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 i_evict  in  1  cache eviction valid (from sa_cache o_evict).
REQ-006 i_evict_addr  in  AW  evicted word address.
REQ-007 i_evict_data  in  DW  evicted dirty data.
REQ-008 i_miss  in  1  cache miss, level, held by cache until o_memory_response.
REQ-009 i_miss_addr  in  AW  miss address {tag,index,offset}.
REQ-010 o_memory_line  out  DW  fill data to cache (i_memory_line).
REQ-011 o_memory_response  out  1  one-cycle fill-valid pulse (i_memory_response).
REQ-012 o_wb_full  out  1  FIFO holds DEPTH entries; cache stalls evictions.
REQ-013 o_overflow  out  1  sticky: eviction presented while full.
REQ-014 o_mem_req / o_mem_we  out  1 / 1  memory request valid / write(1) read(0).
REQ-015 o_mem_addr / o_mem_wdata  out  AW / DW  memory request address / write data.
REQ-016 i_mem_ack / i_mem_rdata  in  1 / DW  memory completion / read data, valid with ack.

Function
REQ-017 FIFO push when i_evict=1 and o_wb_full=0; push with o_wb_full=1 is dropped and sets o_overflow.
REQ-018 Push and pop in one cycle allowed when not full; count unchanged; pointers wrap modulo DEPTH.
REQ-019 FSM states: IDLE, FWD, FILL, DRAIN, RESP.
REQ-020 IDLE, i_miss=1: capture i_miss_addr; FIFO-hit (addr[AW-1:2] equals any valid entry or same-cycle incoming eviction) -> FWD; else -> FILL.
REQ-021 Multiple hits: youngest entry wins (incoming eviction youngest).
REQ-022 IDLE, i_miss=0, FIFO non-empty -> DRAIN with oldest entry.
REQ-023 FWD: load o_memory_line from hit data -> RESP; forwarded miss responds at capture cycle +2, no memory access.
REQ-024 FILL: o_mem_req=1, o_mem_we=0, o_mem_addr=captured addr; on i_mem_ack register i_mem_rdata into o_memory_line -> RESP.
REQ-025 DRAIN: o_mem_req=1, o_mem_we=1, head addr/data; on i_mem_ack pop head -> IDLE.
REQ-026 Request outputs stable from assertion until the cycle i_mem_ack=1; o_mem_req low the following cycle; ack in first request cycle legal.
REQ-027 RESP: o_memory_response=1 exactly one cycle, o_memory_line held until next response; i_miss ignored in RESP -> IDLE.
REQ-028 Miss beats drain only at IDLE; an in-flight drain completes before a miss is served.
REQ-029 Read bypassing queued writes legal only on FIFO-miss (REQ-020 guarantees coherence).
REQ-030 Evictions accepted in every state per REQ-017.
REQ-031 i_mem_ack while o_mem_req=0 ignored.

Reset
REQ-032 rst=0 immediately clears: FSM=IDLE, FIFO empty, pointers 0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_memory_line=0, o_memory_response=0, o_wb_full=0, o_overflow=0.
REQ-033 Reset mid-transaction abandons it; no response or pop afterwards; FIFO contents lost.
REQ-034 First state update on first rising clk after rst returns high.

Verification
REQ-035 Miss 0x0000_1040, FIFO empty, ack 3 cycles after req, rdata 0xDEAD_BEEF -> o_mem_we=0, addr 0x1040, response pulse with line 0xDEAD_BEEF cycle after ack.
REQ-036 Evict (0x2000,0x1111_1111) then (0x2000,0x2222_2222), then miss 0x2000 before drain -> response at capture+2, line 0x2222_2222, no read request.
REQ-037 Four evictions, i_mem_ack held 0 -> o_wb_full=1 after fourth; fifth sets o_overflow=1, FIFO unchanged; drains appear in push order.
REQ-038 Drain in progress (addr 0x3000) when miss 0x4000 arrives -> write acked first, then read 0x4000, then remaining drains.
REQ-039 Eviction same cycle as pop when count=3 -> count stays 3, o_wb_full=0, order preserved.
REQ-040 rst low during FILL with o_mem_req=1 -> o_mem_req=0 asynchronously, no o_memory_response, all outputs per REQ-032.
